// File: rtl/ooo_issue_queue.sv
// Age-ordered issue queue: holds renamed ops until both sources are ready, issues oldest ready op.
// Latency: dispatch-to-issue >= 1 cycle; wakeup-to-eligible 1 cycle. Backpressure: disp_ready = !full && !flush; held when iss_ready=0.
module ooo_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int TAG_W      = 6,
    parameter int PAYLOAD_W  = 32,
    parameter int WAKE_PORTS = 2,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [PAYLOAD_W-1:0]        disp_payload,
    input  logic [TAG_W-1:0]            disp_dst_tag,
    input  logic [TAG_W-1:0]            disp_src1_tag,
    input  logic                        disp_src1_rdy,
    input  logic [TAG_W-1:0]            disp_src2_tag,
    input  logic                        disp_src2_rdy,
    input  logic [WAKE_PORTS-1:0]       wake_valid,
    input  logic [WAKE_PORTS*TAG_W-1:0] wake_tag,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output logic [PAYLOAD_W-1:0]        iss_payload,
    output logic [TAG_W-1:0]            iss_dst_tag,
    output logic [TAG_W-1:0]            iss_src1_tag,
    output logic [TAG_W-1:0]            iss_src2_tag,
    output logic [CW-1:0]               count,
    output logic                        empty,
    output logic                        full
);

    logic [DEPTH-1:0]     vld_q, vld_d, s1r_q, s1r_d, s2r_q, s2r_d;
    logic [PAYLOAD_W-1:0] pay_q [DEPTH];
    logic [PAYLOAD_W-1:0] pay_d [DEPTH];
    logic [TAG_W-1:0]     dst_q [DEPTH];
    logic [TAG_W-1:0]     dst_d [DEPTH];
    logic [TAG_W-1:0]     s1t_q [DEPTH];
    logic [TAG_W-1:0]     s1t_d [DEPTH];
    logic [TAG_W-1:0]     s2t_q [DEPTH];
    logic [TAG_W-1:0]     s2t_d [DEPTH];
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]     older_q [DEPTH];
    logic [DEPTH-1:0]     older_d [DEPTH];
    logic [CW-1:0]        count_q, count_d;

    logic [DEPTH-1:0] elig, sel;
    logic [IW-1:0]    sel_idx, free_idx;
    logic             alloc, issue_fire;

    function automatic logic wake_hit(input logic [TAG_W-1:0] t,
                                      input logic [WAKE_PORTS-1:0] wv,
                                      input logic [WAKE_PORTS*TAG_W-1:0] wt);
        logic h;
        h = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++)
            if (wv[p] && wt[p*TAG_W +: TAG_W] == t) h = 1'b1;
        return h;
    endfunction

    assign elig       = vld_q & s1r_q & s2r_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign disp_ready = !full && !flush;
    assign iss_valid  = (|elig) && !flush;
    assign alloc      = disp_valid && disp_ready;
    assign issue_fire = iss_valid && iss_ready;

    always_comb begin
        logic blk;
        sel      = '0;
        sel_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            blk = 1'b0;
            for (int j = 0; j < DEPTH; j++)
                if (elig[j] && older_q[j][i]) blk = 1'b1;
            sel[i] = elig[i] && !blk;
        end
        for (int i = 0; i < DEPTH; i++)
            if (sel[i]) sel_idx = IW'(i);
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!vld_q[i]) free_idx = IW'(i);
    end

    assign iss_payload  = pay_q[sel_idx];
    assign iss_dst_tag  = dst_q[sel_idx];
    assign iss_src1_tag = s1t_q[sel_idx];
    assign iss_src2_tag = s2t_q[sel_idx];

    always_comb begin
        vld_d   = vld_q;
        s1r_d   = s1r_q;
        s2r_d   = s2r_q;
        pay_d   = pay_q;
        dst_d   = dst_q;
        s1t_d   = s1t_q;
        s2t_d   = s2t_q;
        older_d = older_q;
        count_d = count_q + CW'(alloc) - CW'(issue_fire);
        for (int i = 0; i < DEPTH; i++) begin
            if (wake_hit(s1t_q[i], wake_valid, wake_tag)) s1r_d[i] = 1'b1;
            if (wake_hit(s2t_q[i], wake_valid, wake_tag)) s2r_d[i] = 1'b1;
        end
        if (issue_fire)
            vld_d[sel_idx] = 1'b0;
        if (alloc) begin
            vld_d[free_idx]   = 1'b1;
            pay_d[free_idx]   = disp_payload;
            dst_d[free_idx]   = disp_dst_tag;
            s1t_d[free_idx]   = disp_src1_tag;
            s2t_d[free_idx]   = disp_src2_tag;
            s1r_d[free_idx]   = disp_src1_rdy | wake_hit(disp_src1_tag, wake_valid, wake_tag);
            s2r_d[free_idx]   = disp_src2_rdy | wake_hit(disp_src2_tag, wake_valid, wake_tag);
            older_d[free_idx] = '0;
            for (int j = 0; j < DEPTH; j++)
                older_d[j][free_idx] = vld_q[j];
        end
        if (flush) begin
            vld_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q   <= '0;
            s1r_q   <= '0;
            s2r_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pay_q[i]   <= '0;
                dst_q[i]   <= '0;
                s1t_q[i]   <= '0;
                s2t_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            s1r_q   <= s1r_d;
            s2r_q   <= s2r_d;
            count_q <= count_d;
            pay_q   <= pay_d;
            dst_q   <= dst_d;
            s1t_q   <= s1t_d;
            s2t_q   <= s2t_d;
            older_q <= older_d;
        end
    end

endmodule
